// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/burst/response encodings and small helpers
// used by the bus arbiter and related bus-fabric blocks.
package ahb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  // OR of the indices of all set bits; exact for a one-hot input.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Requester picker: fixed priority (index 0 highest) or round-robin starting
// just after rr_last_i. Returns one-hot, all-zero when nobody requests.
module ahb_rr_pick
  import ahb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] rr_last_i,
  input  logic             rr_mode_i,
  output logic [N-1:0]     pick_o
);

  // Each requester gets a distance from the search start; the smallest wins.
  always_comb begin
    int best_d;
    int d;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pick_o = '0;
    best_d = N;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      d = rr_mode_i ? (i - int'(rr_last_i) - 1) : i;
      if (d < 0) d = d + N;
      if (req_i[i] && (d < best_d)) begin
        best_d = d;
        pick_o = N'(1) << i;
      end
    end
  end

endmodule

// File: rtl/ahb_multi_master_arbiter.sv
// N-master AHB arbiter with master-side multiplexer: registered grant,
// HREADY-aware address/data-phase ownership, lock and burst-hold fairness.
module ahb_multi_master_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ARB_MODE       = 1,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                              HCLK,
  input  logic                              HRESETn,
  input  logic [NUM_MASTERS-1:0]            m_HBUSREQ,
  output logic [NUM_MASTERS-1:0]            m_HGRANT,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_HADDR,
  input  logic [NUM_MASTERS*2-1:0]          m_HTRANS,
  input  logic [NUM_MASTERS-1:0]            m_HWRITE,
  input  logic [NUM_MASTERS*3-1:0]          m_HSIZE,
  input  logic [NUM_MASTERS*3-1:0]          m_HBURST,
  input  logic [NUM_MASTERS*4-1:0]          m_HPROT,
  input  logic [NUM_MASTERS-1:0]            m_HMASTLOCK,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_HWDATA,
  input  logic                              HREADY,
  output logic [ADDR_WIDTH-1:0]             HADDR,
  output logic [1:0]                        HTRANS,
  output logic                              HWRITE,
  output logic [2:0]                        HSIZE,
  output logic [2:0]                        HBURST,
  output logic [3:0]                        HPROT,
  output logic                              HMASTLOCK,
  output logic [DATA_WIDTH-1:0]             HWDATA,
  output logic [2:0]                        HMASTER,
  output logic [2:0]                        HMASTER_DATA
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
    $error("ahb_multi_master_arbiter: NUM_MASTERS must be 2..8");
  end
  if (DEFAULT_MASTER < 0 || DEFAULT_MASTER >= NUM_MASTERS) begin : g_bad_default_master
    $error("ahb_multi_master_arbiter: DEFAULT_MASTER out of range");
  end

  localparam int                     HCW          = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic                   HOLD_LIMIT   = (MAX_HOLD != 0);
  localparam logic [HCW-1:0]         HOLD_MAX     = HCW'(MAX_HOLD);
  localparam logic                   RR_MODE      = (ARB_MODE != 0);
  localparam logic [IDX_W-1:0]       DEF_IDX      = IDX_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT   = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [IDX_W-1:0]       LAST_IDX     = IDX_W'(NUM_MASTERS - 1);

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       rr_last_q, rr_last_d;
  logic [IDX_W-1:0]       hmaster_q, hmaster_d;
  logic [IDX_W-1:0]       hmaster_data_q, hmaster_data_d;
  logic [HCW-1:0]         hold_cnt_q, hold_cnt_d;
  logic                   dp_rst_q, dp_rst_d;

  logic [ADDR_WIDTH-1:0]  own_addr;
  logic [1:0]             own_trans;
  logic                   own_write;
  logic [2:0]             own_size;
  logic [2:0]             own_burst;
  logic [3:0]             own_prot;
  logic                   own_lock;
  logic [DATA_WIDTH-1:0]  own_wdata;

  logic                   lock_hold, burst_hold, own_active, rearb_ok;
  logic [NUM_MASTERS-1:0] pick, next_grant;
  logic [IDX_W-1:0]       grant_idx, pick_idx;

  // Address-phase signals follow HMASTER, write data follows HMASTER_DATA.
  always_comb begin
    own_addr  = m_HADDR[ADDR_WIDTH-1:0];
    own_trans = m_HTRANS[1:0];
    own_write = m_HWRITE[0];
    own_size  = m_HSIZE[2:0];
    own_burst = m_HBURST[2:0];
    own_prot  = m_HPROT[3:0];
    own_lock  = m_HMASTLOCK[0];
    own_wdata = m_HWDATA[DATA_WIDTH-1:0];
    for (int i = 1; i < NUM_MASTERS; i++) begin
      if (hmaster_q == IDX_W'(i)) begin
        own_addr  = m_HADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_trans = m_HTRANS[i*2 +: 2];
        own_write = m_HWRITE[i];
        own_size  = m_HSIZE[i*3 +: 3];
        own_burst = m_HBURST[i*3 +: 3];
        own_prot  = m_HPROT[i*4 +: 4];
        own_lock  = m_HMASTLOCK[i];
      end
      if (hmaster_data_q == IDX_W'(i)) begin
        own_wdata = m_HWDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    // No transfer may leave the bus before the first accepted cycle after reset.
    if (dp_rst_q) own_trans = HTRANS_IDLE;
  end

  assign lock_hold  = own_lock | (own_trans == HTRANS_BUSY);
  assign own_active = (own_trans == HTRANS_NONSEQ) | (own_trans == HTRANS_SEQ);
  assign burst_hold = ((own_trans == HTRANS_SEQ) |
                       ((own_trans == HTRANS_NONSEQ) & (own_burst != HBURST_SINGLE))) &
                      (~HOLD_LIMIT | (hold_cnt_q < HOLD_MAX));
  assign rearb_ok   = HREADY & ~lock_hold & ~burst_hold;

  ahb_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i     (m_HBUSREQ),
    .rr_last_i (rr_last_q),
    .rr_mode_i (RR_MODE),
    .pick_o    (pick)
  );

  assign next_grant = (|m_HBUSREQ) ? pick : DEF_ONEHOT;
  assign grant_idx  = onehot_to_idx(MAX_MASTERS'(grant_q));
  assign pick_idx   = onehot_to_idx(MAX_MASTERS'(pick));

  always_comb begin
    grant_d        = grant_q;
    rr_last_d      = rr_last_q;
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    hold_cnt_d     = hold_cnt_q;
    dp_rst_d       = dp_rst_q;
    if (rearb_ok) begin
      grant_d = next_grant;
      if (|m_HBUSREQ) rr_last_d = pick_idx;
    end
    if (HREADY) begin
      hmaster_d      = grant_idx;
      hmaster_data_d = hmaster_q;
      dp_rst_d       = 1'b0;
      if (grant_idx != hmaster_q) begin
        hold_cnt_d = '0;
      end else if (own_active && HOLD_LIMIT && (hold_cnt_q < HOLD_MAX)) begin
        hold_cnt_d = hold_cnt_q + HCW'(1);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      grant_q        <= DEF_ONEHOT;
      rr_last_q      <= LAST_IDX;
      hmaster_q      <= DEF_IDX;
      hmaster_data_q <= DEF_IDX;
      hold_cnt_q     <= '0;
      dp_rst_q       <= 1'b1;
    end else begin
      grant_q        <= grant_d;
      rr_last_q      <= rr_last_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      hold_cnt_q     <= hold_cnt_d;
      dp_rst_q       <= dp_rst_d;
    end
  end

  assign m_HGRANT     = grant_q;
  assign HADDR        = own_addr;
  assign HTRANS       = own_trans;
  assign HWRITE       = own_write;
  assign HSIZE        = own_size;
  assign HBURST       = own_burst;
  assign HPROT        = own_prot;
  assign HMASTLOCK    = own_lock;
  assign HWDATA       = own_wdata;
  assign HMASTER      = hmaster_q;
  assign HMASTER_DATA = hmaster_data_q;

endmodule

// File: tb/tb_ahb_multi_master_arbiter.sv
// Bench for ahb_multi_master_arbiter: two configurations (2-master fixed, 4-master
// round-robin) driven side by side and compared every cycle against a rule-level model.
module tb_ahb_multi_master_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000, B_INCR = 3'b001;

  typedef struct {int n; int mode; int dflt; int max_hold;} cfg_t;
  typedef struct {int g; int hm; int hmd; int hold; int rr_last; bit dp_rst;} st_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cfg_t cfg [2];
  st_t  st  [2];
  int   checks = 0;
  int   errors = 0;

  // Per-configuration, per-master stimulus
  logic [7:0]  req [2];
  logic [1:0]  tr  [2][8];
  logic [2:0]  bu  [2][8];
  logic        lk  [2][8];
  logic        wr  [2][8];
  logic [2:0]  sz  [2][8];
  logic [3:0]  pr  [2][8];
  logic [31:0] ad  [2][8];
  logic [31:0] wd  [2][8];
  logic        rdy [2];

  logic [7:0]   f_req [2], f_wr [2], f_lk [2];
  logic [15:0]  f_tr  [2];
  logic [23:0]  f_bu  [2], f_sz [2];
  logic [31:0]  f_pr  [2];
  logic [255:0] f_ad  [2], f_wd [2];

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      f_req[u] = req[u];
      f_wr[u] = '0; f_lk[u] = '0; f_tr[u] = '0; f_bu[u] = '0;
      f_sz[u] = '0; f_pr[u] = '0; f_ad[u] = '0; f_wd[u] = '0;
      for (int i = 0; i < 8; i++) begin
        f_wr[u][i]         = wr[u][i];
        f_lk[u][i]         = lk[u][i];
        f_tr[u][i*2 +: 2]  = tr[u][i];
        f_bu[u][i*3 +: 3]  = bu[u][i];
        f_sz[u][i*3 +: 3]  = sz[u][i];
        f_pr[u][i*4 +: 4]  = pr[u][i];
        f_ad[u][i*32 +: 32] = ad[u][i];
        f_wd[u][i*32 +: 32] = wd[u][i];
      end
    end
  end

  logic [1:0]  a_grant;  logic [3:0]  b_grant;
  logic [31:0] a_haddr,  b_haddr,  a_hwdata, b_hwdata;
  logic [1:0]  a_htrans, b_htrans;
  logic        a_hwrite, b_hwrite, a_hlock, b_hlock;
  logic [2:0]  a_hsize,  b_hsize,  a_hburst, b_hburst, a_hm, b_hm, a_hmd, b_hmd;
  logic [3:0]  a_hprot,  b_hprot;

  ahb_multi_master_arbiter #(
    .NUM_MASTERS(2), .ARB_MODE(0), .DEFAULT_MASTER(0), .MAX_HOLD(16),
    .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) u_dut_a (
    .HCLK(clk), .HRESETn(rst_n),
    .m_HBUSREQ(f_req[0][1:0]), .m_HGRANT(a_grant),
    .m_HADDR(f_ad[0][63:0]), .m_HTRANS(f_tr[0][3:0]), .m_HWRITE(f_wr[0][1:0]),
    .m_HSIZE(f_sz[0][5:0]), .m_HBURST(f_bu[0][5:0]), .m_HPROT(f_pr[0][7:0]),
    .m_HMASTLOCK(f_lk[0][1:0]), .m_HWDATA(f_wd[0][63:0]), .HREADY(rdy[0]),
    .HADDR(a_haddr), .HTRANS(a_htrans), .HWRITE(a_hwrite), .HSIZE(a_hsize),
    .HBURST(a_hburst), .HPROT(a_hprot), .HMASTLOCK(a_hlock), .HWDATA(a_hwdata),
    .HMASTER(a_hm), .HMASTER_DATA(a_hmd)
  );

  ahb_multi_master_arbiter #(
    .NUM_MASTERS(4), .ARB_MODE(1), .DEFAULT_MASTER(2), .MAX_HOLD(4),
    .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) u_dut_b (
    .HCLK(clk), .HRESETn(rst_n),
    .m_HBUSREQ(f_req[1][3:0]), .m_HGRANT(b_grant),
    .m_HADDR(f_ad[1][127:0]), .m_HTRANS(f_tr[1][7:0]), .m_HWRITE(f_wr[1][3:0]),
    .m_HSIZE(f_sz[1][11:0]), .m_HBURST(f_bu[1][11:0]), .m_HPROT(f_pr[1][15:0]),
    .m_HMASTLOCK(f_lk[1][3:0]), .m_HWDATA(f_wd[1][127:0]), .HREADY(rdy[1]),
    .HADDR(b_haddr), .HTRANS(b_htrans), .HWRITE(b_hwrite), .HSIZE(b_hsize),
    .HBURST(b_hburst), .HPROT(b_hprot), .HMASTLOCK(b_hlock), .HWDATA(b_hwdata),
    .HMASTER(b_hm), .HMASTER_DATA(b_hmd)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic st_t model_reset(int u);
    st_t s;
    s.g = cfg[u].dflt; s.hm = cfg[u].dflt; s.hmd = cfg[u].dflt;
    s.hold = 0; s.rr_last = cfg[u].n - 1; s.dp_rst = 1'b1;
    return s;
  endfunction

  function automatic st_t model_next(int u);
    st_t s, nx;
    cfg_t c;
    logic [1:0] et;
    bit lock_h, burst_h, rearb, any;
    int p;
    s = st[u]; nx = st[u]; c = cfg[u];
    et      = s.dp_rst ? T_IDLE : tr[u][s.hm];
    lock_h  = lk[u][s.hm] || (et == T_BUSY);
    burst_h = ((et == T_SEQ) || (et == T_NSEQ && bu[u][s.hm] != B_SINGLE)) &&
              (c.max_hold == 0 || s.hold < c.max_hold);
    rearb   = rdy[u] && !lock_h && !burst_h;
    any = 1'b0; p = c.dflt;
    if (c.mode == 0) begin
      for (int i = c.n - 1; i >= 0; i--) if (req[u][i]) begin p = i; any = 1'b1; end
    end else begin
      for (int k = c.n; k >= 1; k--) begin
        int j;
        j = (s.rr_last + k) % c.n;
        if (req[u][j]) begin p = j; any = 1'b1; end
      end
    end
    if (rearb) begin
      nx.g = p;
      if (any) nx.rr_last = p;
    end
    if (rdy[u]) begin
      nx.hm = s.g; nx.hmd = s.hm; nx.dp_rst = 1'b0;
      if (s.g != s.hm) nx.hold = 0;
      else if ((et == T_NSEQ || et == T_SEQ) && c.max_hold > 0 && s.hold < c.max_hold)
        nx.hold = s.hold + 1;
    end
    return nx;
  endfunction

  task automatic compare(int u);
    logic [7:0] og; logic [31:0] oa, ow; logic [1:0] ot; logic owr, olk;
    logic [2:0] osz, obu, ohm, ohmd; logic [3:0] opr;
    int hm, hmd;
    hm = st[u].hm; hmd = st[u].hmd;
    if (u == 0) begin
      og = 8'(a_grant); oa = a_haddr; ow = a_hwdata; ot = a_htrans; owr = a_hwrite; olk = a_hlock;
      osz = a_hsize; obu = a_hburst; ohm = a_hm; ohmd = a_hmd; opr = a_hprot;
    end else begin
      og = 8'(b_grant); oa = b_haddr; ow = b_hwdata; ot = b_htrans; owr = b_hwrite; olk = b_hlock;
      osz = b_hsize; obu = b_hburst; ohm = b_hm; ohmd = b_hmd; opr = b_hprot;
    end
    check($sformatf("u%0d grant", u),        64'(og),   64'(1) << st[u].g);
    check($sformatf("u%0d hmaster", u),      64'(ohm),  64'(hm));
    check($sformatf("u%0d hmaster_data", u), 64'(ohmd), 64'(hmd));
    check($sformatf("u%0d htrans", u),       64'(ot),   64'(st[u].dp_rst ? T_IDLE : tr[u][hm]));
    check($sformatf("u%0d haddr", u),        64'(oa),   64'(ad[u][hm]));
    check($sformatf("u%0d hwrite", u),       64'(owr),  64'(wr[u][hm]));
    check($sformatf("u%0d hsize", u),        64'(osz),  64'(sz[u][hm]));
    check($sformatf("u%0d hburst", u),       64'(obu),  64'(bu[u][hm]));
    check($sformatf("u%0d hprot", u),        64'(opr),  64'(pr[u][hm]));
    check($sformatf("u%0d hmastlock", u),    64'(olk),  64'(lk[u][hm]));
    check($sformatf("u%0d hwdata", u),       64'(ow),   64'(wd[u][hmd]));
  endtask

  // Called at a falling edge with this cycle's inputs applied; returns at the next one.
  task automatic tick();
    st_t nx [2];
    #1;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) st[u] = model_reset(u);
      compare(u);
    end
    for (int u = 0; u < 2; u++) nx[u] = rst_n ? model_next(u) : model_reset(u);
    @(posedge clk);
    st = nx;
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int u = 0; u < 2; u++) begin
      req[u] = '0; rdy[u] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        tr[u][i] = T_IDLE; bu[u][i] = B_SINGLE; lk[u][i] = 1'b0;
        wr[u][i] = 1'($urandom); sz[u][i] = 3'($urandom); pr[u][i] = 4'($urandom);
        ad[u][i] = $urandom; wd[u][i] = $urandom;
      end
    end
  endtask

  task automatic set_m(int u, int i, bit r, logic [1:0] t, logic [2:0] b, bit l);
    req[u][i] = r; tr[u][i] = t; bu[u][i] = b; lk[u][i] = l;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    cfg[0] = '{n: 2, mode: 0, dflt: 0, max_hold: 16};
    cfg[1] = '{n: 4, mode: 1, dflt: 2, max_hold: 4};
    rst_n = 1'b0;
    idle_all();
    st[0] = model_reset(0);
    st[1] = model_reset(1);
    @(negedge clk);

    // Reset state; HTRANS stays IDLE until the first HREADY cycle after reset.
    set_m(0, 0, 0, T_NSEQ, B_SINGLE, 0);
    tick();
    check("reset grant", 64'(a_grant), 64'h1);
    check("reset hmaster", 64'(a_hm), 64'h0);
    check("reset htrans", 64'(a_htrans), 64'(T_IDLE));
    check("reset grant b", 64'(b_grant), 64'h4);
    rst_n = 1'b1;
    rdy[0] = 1'b0;
    tick();
    check("dp reset htrans", 64'(a_htrans), 64'(T_IDLE));
    rdy[0] = 1'b1;
    set_m(0, 0, 0, T_IDLE, B_SINGLE, 0);
    repeat (3) tick();
    check("idle grant", 64'(a_grant), 64'h1);

    // Fixed priority: master 0 keeps the bus while requesting.
    do_reset();
    set_m(0, 0, 1, T_NSEQ, B_SINGLE, 0);
    set_m(0, 1, 1, T_NSEQ, B_SINGLE, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("fixed hold grant", 64'(a_grant), 64'h1);
    end
    set_m(0, 0, 0, T_IDLE, B_SINGLE, 0);
    tick();
    check("fixed release grant", 64'(a_grant), 64'h2);
    tick();
    check("fixed release hmaster", 64'(a_hm), 64'h1);

    // Round-robin rotation with single transfers.
    do_reset();
    for (int i = 0; i < 4; i++) set_m(1, i, 1, T_NSEQ, B_SINGLE, 0);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("rr hmaster", 64'(b_hm), 64'(k % 4));
      if (k > 0) check("rr hmaster_data", 64'(b_hmd), 64'((k + 3) % 4));
      tick();
    end

    // Wait states: write data stays with the stalled data owner.
    do_reset();
    set_m(0, 0, 1, T_NSEQ, B_SINGLE, 0);
    wr[0][0] = 1'b1; wd[0][0] = 32'hDEADBEEF; wd[0][1] = 32'h11111111;
    tick();
    tick();
    set_m(0, 0, 0, T_IDLE, B_SINGLE, 0);
    set_m(0, 1, 1, T_NSEQ, B_SINGLE, 0);
    rdy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall hwdata", 64'(a_hwdata), 64'hDEADBEEF);
      check("stall hmaster", 64'(a_hm), 64'h0);
    end
    rdy[0] = 1'b1;
    tick();
    check("resume hmaster", 64'(a_hm), 64'h0);
    check("resume grant", 64'(a_grant), 64'h2);
    tick();
    check("handover hmaster", 64'(a_hm), 64'h1);

    // Locked 20-beat INCR beyond MAX_HOLD=16 is never broken.
    do_reset();
    set_m(0, 1, 1, T_IDLE, B_SINGLE, 0);
    tick();
    tick();
    check("lock owner", 64'(a_hm), 64'h1);
    set_m(0, 0, 1, T_NSEQ, B_SINGLE, 0);
    for (int b = 0; b < 20; b++) begin
      set_m(0, 1, 1, (b == 0) ? T_NSEQ : T_SEQ, B_INCR, 1);
      tick();
      check("locked grant", 64'(a_grant), 64'h2);
    end
    set_m(0, 1, 0, T_IDLE, B_SINGLE, 0);
    tick();
    check("unlock grant", 64'(a_grant), 64'h1);

    // Unlocked INCR cut after MAX_HOLD=4 accepted beats, then reset mid-burst.
    do_reset();
    set_m(1, 0, 1, T_IDLE, B_SINGLE, 0);
    tick();
    tick();
    check("burst owner", 64'(b_hm), 64'h0);
    set_m(1, 2, 1, T_NSEQ, B_SINGLE, 0);
    for (int b = 0; b < 6; b++) begin
      set_m(1, 0, 1, (b == 0) ? T_NSEQ : T_SEQ, B_INCR, 0);
      tick();
      if (b < 4) check("maxhold keep", 64'(b_grant), 64'h1);
      else if (b == 4) check("maxhold move", 64'(b_grant), 64'h4);
    end
    rst_n = 1'b0;
    tick();
    check("midreset grant", 64'(b_grant), 64'h4);
    check("midreset htrans", 64'(b_htrans), 64'(T_IDLE));
    check("midreset hmaster", 64'(b_hm), 64'h2);
    rst_n = 1'b1;

    // Randomised traffic on both configurations.
    for (int c = 0; c < 1500; c++) begin
      for (int u = 0; u < 2; u++) begin
        rdy[u] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 8; i++) begin
          req[u][i] = ($urandom_range(0, 9) < 6);
          tr[u][i]  = 2'($urandom);
          bu[u][i]  = ($urandom_range(0, 1) == 0) ? B_SINGLE : 3'($urandom);
          lk[u][i]  = ($urandom_range(0, 15) == 0);
          wr[u][i]  = 1'($urandom);
          sz[u][i]  = 3'($urandom);
          pr[u][i]  = 4'($urandom);
          ad[u][i]  = $urandom;
          wd[u][i]  = $urandom;
        end
      end
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_multi_master_arbiter.md
Name: ahb_multi_master_arbiter

Overview:
- Parametrised N-master AHB arbiter and master-side multiplexer for the system bus.
- Replaces the fixed CPU/DMA two-way grant-and-mux with a generic block.
- Adds selectable fixed-priority or round-robin arbitration, HREADY-aware ownership handover, locked-sequence hold, burst-hold fairness limit, default master and separate address-phase/data-phase owners.
- Sits between masters (core, DMA, debug, future accelerators) and the shared decoder/slave fabric.

Parameters:
- NUM_MASTERS, 2: number of masters, 2..8.
- ARB_MODE, 1: 0 = fixed priority (index 0 highest); 1 = round-robin.
- DEFAULT_MASTER, 0: index granted when no request is pending.
- MAX_HOLD, 16: max consecutive accepted transfers before forced re-arbitration; 0 disables the limit.
- ADDR_WIDTH, 32: HADDR width.
- DATA_WIDTH, 32: HWDATA/HRDATA width.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- m_HBUSREQ  in  NUM_MASTERS  per-master bus request.
- m_HGRANT  out  NUM_MASTERS  one-hot grant, registered.
- m_HADDR  in  NUM_MASTERS*ADDR_WIDTH  flattened; master i at slice i.
- m_HTRANS  in  NUM_MASTERS*2  per-master HTRANS.
- m_HWRITE  in  NUM_MASTERS  per-master HWRITE.
- m_HSIZE  in  NUM_MASTERS*3  per-master HSIZE.
- m_HBURST  in  NUM_MASTERS*3  per-master HBURST.
- m_HPROT  in  NUM_MASTERS*4  per-master HPROT.
- m_HMASTLOCK  in  NUM_MASTERS  per-master lock.
- m_HWDATA  in  NUM_MASTERS*DATA_WIDTH  per-master write data.
- HREADY  in  1  shared ready from the slave mux.
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK  out  std widths  address-phase signals of the address owner.
- HWDATA  out  DATA_WIDTH  write data of the data owner.
- HMASTER  out  3  current address-phase owner index.
- HMASTER_DATA  out  3  current data-phase owner index.

Behaviour:
- Reset (async, HRESETn=0):
  - grant_r = one-hot DEFAULT_MASTER; HMASTER = HMASTER_DATA = DEFAULT_MASTER.
  - hold_cnt = 0; rr_last = NUM_MASTERS-1.
  - Muxed outputs follow DEFAULT_MASTER inputs, except HTRANS forced IDLE (2'b00) while the data-phase reset flag is set, i.e. until the first HREADY=1 cycle after reset.
- Arbitration is combinational to next_grant; grant_r updates every cycle at the HCLK edge only when rearb_ok.
- rearb_ok = HREADY & ~lock_hold & ~burst_hold.
- lock_hold: HMASTLOCK of the address owner is 1, or the owner's HTRANS is BUSY (01).
- burst_hold: owner HTRANS == SEQ (11) or NONSEQ with HBURST != SINGLE, AND (MAX_HOLD == 0 or hold_cnt < MAX_HOLD).
  - Lock overrides MAX_HOLD. MAX_HOLD never breaks a locked sequence.
- Fixed mode: lowest-index requester wins.
- Round-robin mode: first requester searching from rr_last+1 upward (modulo N) wins. rr_last = the granted index whenever the grant changes to a requester.
- No requests: next_grant = DEFAULT_MASTER. The granted master drives IDLE per protocol.
- Ownership handover: HMASTER <= index(grant_r) on each HCLK edge with HREADY=1; HMASTER_DATA <= HMASTER on the same edges.
  - With HREADY=0, both hold and HWDATA stays on the stalled data owner.
- hold_cnt:
  - Cleared when HMASTER changes.
  - Incremented (saturating at MAX_HOLD) on each HREADY=1 cycle in which the owner's HTRANS is NONSEQ or SEQ.
- Address-phase muxes select on HMASTER; HWDATA selects on HMASTER_DATA. Zero added latency; purely combinational mux after the registers.
- Simultaneous request from a new master and release by the owner in the same cycle: the new master is granted next cycle if HREADY=1.
- Owner drops its request mid-burst: burst_hold still holds until the owner issues non-SEQ or MAX_HOLD is reached.
- HRESP ERROR has no special handling in the arbiter; the two-cycle response is passed by the slave mux.
- Out-of-range DEFAULT_MASTER: elaboration error via generate check.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - HBURST SINGLE.
  - HRESP OKAY/ERROR.
  - Helper function for onehot-to-index.
- Sub-module ahb_rr_pick(N): masked round-robin/priority picker taking req, rr_last and mode, returning a one-hot result. Reused by the future APB multi-slave bridge.

Test Plan:
- Reset with m_HBUSREQ=0 -> m_HGRANT=01, HMASTER=0, HTRANS=IDLE; after release with no requests, grant stays 01.
- Fixed mode, N=2, both request, HREADY=1 -> grant 01 continuously; master 1 granted only after master 0 drops its request and issues IDLE.
- Round-robin, N=4, all request, SINGLE transfers, HREADY=1 -> HMASTER sequence 0,1,2,3,0; HMASTER_DATA lags by exactly one cycle.
- Handover under wait states: master 0 writes 0xDEADBEEF, slave holds HREADY=0 for 3 cycles while master 1 requests -> HWDATA=0xDEADBEEF throughout; HMASTER changes only on the cycle after HREADY returns to 1.
- Locked INCR sequence of 20 beats from master 1 with MAX_HOLD=16, master 0 requesting -> no grant change until HMASTLOCK=0 and a non-SEQ transfer.
- Unlocked INCR of 20 beats, MAX_HOLD=4, master 2 requesting -> grant moves to master 2 after 4 accepted beats. Asserting HRESETn=0 mid-burst -> grant immediately returns to DEFAULT_MASTER and HTRANS=IDLE.
